periph_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one memory-mapped peripheral bus port (timer_mem style: enable/wr_en/addr/i_data/be in; ready/o_data/bus_err out) among NREQ requester FSMs.
- Sits between requester controllers (e.g. a PWM-update FSM and a counter-polling FSM) and a single peripheral instance such as timer_mem.
- Registers and holds the winning request for the full transaction and returns completion to the winner only.
- Includes a watchdog that completes hung transactions with bus_err.

---
 rtl/periph_bus_arbiter_pkg.sv | 29 ++
 rtl/periph_bus_arbiter_rr_pick.sv | 37 +++
 rtl/periph_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_arbiter_pkg.sv
// periph_bus_arbiter_pkg: shared definitions for the peripheral bus arbiter.
//   state_t          : arbiter FSM states (IDLE=0, BUSY=1, DONE=2)
//   TIMEOUT_DISABLED : TIMEOUT value that turns the watchdog off
//   idx_w/cnt_w/be_w : width helpers for requester index, watchdog counter
//                      and byte-enable fields
package periph_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int TIMEOUT_DISABLED = 0;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The counter only has to reach TIMEOUT-1.
  function automatic int cnt_w(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req    [NREQ] : request vector
//   last   [IW]   : index of the previous winner
//   valid         : at least one request is set
//   winner [IW]   : first set bit scanning from last+1 upward, modulo NREQ
//   onehot [NREQ] : one-hot form of winner (0 when not valid)
module rr_pick
  import periph_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   winner,
  output logic [NREQ-1:0] onehot
);

  always_comb begin
    int idx;
    idx    = 0;
    valid  = 1'b0;
    winner = '0;
    onehot = '0;
    // Scanning offsets 1..NREQ puts the previous winner last in line.
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last) + off) % NREQ;
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        winner      = IW'(idx);
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: round-robin sharing of one memory-mapped peripheral
// port among NREQ requesters, with a watchdog for hung transactions.
//   clk, rst                 : clock, synchronous active-high reset
//   req_enable/req_wr_en     : per-requester request and direction
//   req_addr/req_data/req_be : flattened per-requester address, data, byte enables
//   req_ready/req_bus_err    : one-cycle completion pulse and error to the winner
//   req_o_data               : read data broadcast, held until next completion
//   grant                    : one-hot current owner, 0 when idle
//   s_enable..s_be           : registered request to the peripheral
//   s_ready/s_bus_err/s_o_data : peripheral response
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_enable,
  input  logic [NREQ-1:0]        req_wr_en,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*DW-1:0]     req_data,
  input  logic [NREQ*DW/8-1:0]   req_be,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        req_bus_err,
  output logic [DW-1:0]          req_o_data,
  output logic [NREQ-1:0]        grant,
  output logic                   s_enable,
  output logic                   s_wr_en,
  output logic [AW-1:0]          s_addr,
  output logic [DW-1:0]          s_data,
  output logic [be_w(DW)-1:0]    s_be,
  input  logic                   s_ready,
  input  logic                   s_bus_err,
  input  logic [DW-1:0]          s_o_data
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = cnt_w(TIMEOUT);
  localparam int BW = be_w(DW);

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [CW-1:0]   cnt;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_onehot;

  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [BW-1:0]   sel_be;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req_enable),
    .last   (last_grant),
    .valid  (pick_vld),
    .winner (pick_idx),
    .onehot (pick_onehot)
  );

  // Mux the winning requester's fields out of the flattened buses.
  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_be   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_wr   = req_wr_en[i];
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
        sel_be   = req_be[i*BW +: BW];
      end
    end
  end

  wire tmo_hit = (TIMEOUT != TIMEOUT_DISABLED) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_grant  <= IW'(NREQ - 1);
      cnt         <= '0;
      grant       <= '0;
      s_enable    <= 1'b0;
      s_wr_en     <= 1'b0;
      s_addr      <= '0;
      s_data      <= '0;
      s_be        <= '0;
      req_ready   <= '0;
      req_bus_err <= '0;
      req_o_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            s_enable   <= 1'b1;
            s_wr_en    <= sel_wr;
            s_addr     <= sel_addr;
            s_data     <= sel_data;
            s_be       <= sel_be;
            grant      <= pick_onehot;
            last_grant <= pick_idx;
            cnt        <= '0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // grant is already one-hot on the winner, so it doubles as the
          // per-requester completion mask. s_ready beats the watchdog.
          if (s_ready) begin
            req_ready   <= grant;
            req_bus_err <= s_bus_err ? grant : '0;
            req_o_data  <= s_o_data;
            s_enable    <= 1'b0;
            s_wr_en     <= 1'b0;
            state       <= ST_DONE;
          end else if (tmo_hit) begin
            req_ready   <= grant;
            req_bus_err <= grant;
            req_o_data  <= '0;
            s_enable    <= 1'b0;
            s_wr_en     <= 1'b0;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          // One idle cycle lets the winner drop req_enable before re-arbitration.
          req_ready   <= '0;
          req_bus_err <= '0;
          grant       <= '0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
module tb_periph_bus_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_enable, req_wr_en;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ*DW/8-1:0] req_be;
  logic [NREQ-1:0]      req_ready, req_bus_err, grant;
  logic [DW-1:0]        req_o_data;
  logic                 s_enable, s_wr_en;
  logic [AW-1:0]        s_addr;
  logic [DW-1:0]        s_data;
  logic [DW/8-1:0]      s_be;
  logic                 s_ready, s_bus_err;
  logic [DW-1:0]        s_o_data;

  periph_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_enable(req_enable), .req_wr_en(req_wr_en), .req_addr(req_addr),
    .req_data(req_data), .req_be(req_be),
    .req_ready(req_ready), .req_bus_err(req_bus_err), .req_o_data(req_o_data),
    .grant(grant),
    .s_enable(s_enable), .s_wr_en(s_wr_en), .s_addr(s_addr), .s_data(s_data),
    .s_be(s_be), .s_ready(s_ready), .s_bus_err(s_bus_err), .s_o_data(s_o_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          lat;    // BUSY cycle on which s_ready is given; 0 = never
    logic [31:0] rdata;
    logic        serr;
  } vec_t;

  typedef struct {
    logic [1:0]  rdy;
    logic [1:0]  err;
    logic [31:0] dat;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    exp_t e, got_e;
    logic tmo;
    int   busy;
    logic [1:0] oh;
    oh = 2'b01 << v.id;
    tmo = (v.lat == 0) || (v.lat > TMO);
    busy = tmo ? TMO : v.lat;
    e.rdy = oh;
    e.err = (tmo || v.serr) ? oh : 2'b00;
    e.dat = tmo ? 32'h0 : v.rdata;

    req_enable[v.id]           = 1'b1;
    req_wr_en[v.id]            = v.wr;
    req_addr[v.id*AW +: AW]    = v.addr;
    req_data[v.id*DW +: DW]    = v.data;
    req_be[v.id*4 +: 4]        = v.be;
    sb.push_back(e);
    tick();
    chk("s_enable_after_req", 64'(s_enable), 64'(1));
    chk("grant", 64'(grant), 64'(oh));
    chk("s_wr_en", 64'(s_wr_en), 64'(v.wr));
    chk("s_addr", 64'(s_addr), 64'(v.addr));
    chk("s_data", 64'(s_data), 64'(v.data));
    chk("s_be", 64'(s_be), 64'(v.be));
    // Changes on the requester side while BUSY must not reach the bus.
    req_wr_en[v.id]        = ~v.wr;
    req_addr[v.id*AW +: AW] = ~v.addr;
    req_data[v.id*DW +: DW] = ~v.data;
    for (int k = 0; k < busy - 1; k++) tick();
    chk("busy_s_enable", 64'(s_enable), 64'(1));
    chk("busy_no_ready", 64'(req_ready), 64'(0));
    chk("busy_s_addr_held", 64'(s_addr), 64'(v.addr));
    chk("busy_s_data_held", 64'(s_data), 64'(v.data));
    s_o_data  = v.rdata;
    s_bus_err = v.serr;
    s_ready   = !tmo;
    tick();
    s_ready   = 1'b0;
    s_bus_err = 1'b0;
    got_e = sb.pop_front();
    chk("req_ready", 64'(req_ready), 64'(got_e.rdy));
    chk("req_bus_err", 64'(req_bus_err), 64'(got_e.err));
    chk("req_o_data", 64'(req_o_data), 64'(got_e.dat));
    chk("s_enable_drop", 64'(s_enable), 64'(0));
    req_enable[v.id] = 1'b0;
    tick();
    chk("ready_pulse_end", 64'(req_ready), 64'(0));
    chk("bus_err_clear", 64'(req_bus_err), 64'(0));
    chk("grant_idle", 64'(grant), 64'(0));
    chk("o_data_held", 64'(req_o_data), 64'(got_e.dat));
  endtask

  initial begin
    vecs[0] = '{0, 1'b1, 32'h10, 32'hFF,       4'hF, 2, 32'h0,        1'b0};
    vecs[1] = '{1, 1'b0, 32'h20, 32'h0,        4'hF, 1, 32'hA5,       1'b0};
    vecs[2] = '{0, 1'b0, 32'h24, 32'h0,        4'hF, 3, 32'h12345678, 1'b1};
    vecs[3] = '{1, 1'b1, 32'h30, 32'hDEADBEEF, 4'h3, 8, 32'h55,       1'b0};
    vecs[4] = '{0, 1'b1, 32'h40, 32'h11,       4'hF, 0, 32'h77,       1'b0};
    vecs[5] = '{1, 1'b0, 32'h44, 32'h0,        4'hC, 0, 32'h99,       1'b1};

    req_enable = '0; req_wr_en = '0; req_addr = '0; req_data = '0; req_be = '0;
    s_ready = 1'b0; s_bus_err = 1'b0; s_o_data = '0;
    do_reset();
    chk("rst_s_enable", 64'(s_enable), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_o_data", 64'(req_o_data), 64'(0));
    chk("rst_s_addr", 64'(s_addr), 64'(0));

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // Contention: both requesters assert together right after reset.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e.rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      e.err = 2'b00;
      e.dat = 32'(i);
      sb.push_back(e);
    end
    req_enable = 2'b11;
    for (int t = 0; t < 6; t++) begin
      exp_t e;
      int   n;
      n = 0;
      while (!s_enable && n < 10) begin
        tick();
        n++;
      end
      e = sb.pop_front();
      chk("rr_s_enable", 64'(s_enable), 64'(1));
      chk("rr_grant", 64'(grant), 64'(e.rdy));
      s_ready  = 1'b1;
      s_o_data = 32'(t);
      tick();
      s_ready  = 1'b0;
      chk("rr_ready", 64'(req_ready), 64'(e.rdy));
      chk("rr_o_data", 64'(req_o_data), 64'(e.dat));
      tick();
    end
    req_enable = '0;
    tick();

    // Reset while BUSY, then a late s_ready.
    req_enable = 2'b10;
    tick();
    chk("mid_busy_s_enable", 64'(s_enable), 64'(1));
    chk("mid_busy_grant", 64'(grant), 64'(2'b10));
    req_enable = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_s_enable", 64'(s_enable), 64'(0));
    chk("mrst_grant", 64'(grant), 64'(0));
    chk("mrst_s_addr", 64'(s_addr), 64'(0));
    chk("mrst_o_data", 64'(req_o_data), 64'(0));
    s_ready  = 1'b1;
    s_o_data = 32'hBAD0BAD0;
    tick();
    s_ready = 1'b0;
    chk("late_ready_ignored", 64'(req_ready), 64'(0));
    chk("late_o_data_ignored", 64'(req_o_data), 64'(0));
    chk("late_s_enable", 64'(s_enable), 64'(0));
    req_enable = 2'b11;
    tick();
    chk("first_grant_after_rst", 64'(grant), 64'(2'b01));
    req_enable = '0;
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    chk("post_rst_ready", 64'(req_ready), 64'(2'b01));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
